prefetch_stream_buffer: RTL

- Stream buffer directly downstream of the prefetcher core. It captures the prefetcher's dual-lane write stream (w_addr/w_data/strBufWren) into a small fully-associative store.
- It serves the prefetcher's dual-lane strBuf read requests with the wait_strBuf / strBuf_data_ready handshake.
- Replacement is FIFO-order; no backing memory. A miss returns a hit=0 flag, and the requester falls back to the cache path.

---
 rtl/strbuf_pkg.sv | 21 ++
 rtl/strbuf_cam_match.sv | 28 ++
 rtl/prefetch_stream_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/strbuf_pkg.sv
// Shared types and default sizes for the prefetch stream buffer.
// Entry layout is {valid, word tag, data}.
package strbuf_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int TAG_W      = DEF_ADDR_W - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DEF_DATA_W-1:0] data;
    } strbuf_entry_t;

    typedef enum logic {
        SB_IDLE,
        SB_LOOKUP
    } sb_state_e;

endpackage

// File: rtl/strbuf_cam_match.sv
// One-lane tag compare across all entries.
// Returns hit and the lowest matching index.
module strbuf_cam_match
    import strbuf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]            i_tag,
    output logic                        o_hit,
    output logic [IDX_W-1:0]            o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        // Downward scan so the lowest matching index is the one kept.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prefetch_stream_buffer.sv
// Fully-associative FIFO-replacement stream buffer fed by the
// prefetcher's dual-lane writes and serving dual-lane lookups.
module prefetch_stream_buffer
    import strbuf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [1:0]                   strBufWren,
    input  logic [1:0][ADDR_W-1:0]       w_addr,
    input  logic [1:0][DATA_W-1:0]       w_data,
    input  logic                         strBuf_data_req,
    input  logic [1:0][ADDR_W-1:0]       strBuf_r_addr,
    output logic                         wait_strBuf,
    output logic                         strBuf_data_ready,
    output logic [1:0][DATA_W-1:0]       strBuf_data,
    output logic [1:0]                   strBuf_hit,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    strbuf_entry_t r_ent [DEPTH];
    logic [IDX_W-1:0] r_ptr;
    logic [OCC_W-1:0] r_occ;
    sb_state_e r_state;
    logic [1:0][TAG_W-1:0] r_rtag;
    logic r_wait;
    logic r_ready;
    logic [1:0][DATA_W-1:0] r_data;
    logic [1:0] r_hit;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0][TAG_W-1:0] w_tags;
    logic [TAG_W-1:0] w_wtag0, w_wtag1;
    logic w_whit0, w_whit1, w_rhit0, w_rhit1;
    logic [IDX_W-1:0] w_widx0, w_widx1, w_ridx0, w_ridx1;
    logic w_same, w_evict, w_alloc0, w_alloc1;
    logic [IDX_W-1:0] w_idx0, w_idx1;
    logic [1:0] w_nalloc;
    logic [OCC_W-1:0] w_occ_sum;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_tags[i]  = r_ent[i].tag;
        end
    end

    assign w_wtag0 = w_addr[0][ADDR_W-1:2];
    assign w_wtag1 = w_addr[1][ADDR_W-1:2];

    strbuf_cam_match #(.DEPTH(DEPTH)) u_wcam0 (
        .i_valid(w_valid), .i_tags(w_tags), .i_tag(w_wtag0),
        .o_hit(w_whit0), .o_idx(w_widx0)
    );
    strbuf_cam_match #(.DEPTH(DEPTH)) u_wcam1 (
        .i_valid(w_valid), .i_tags(w_tags), .i_tag(w_wtag1),
        .o_hit(w_whit1), .o_idx(w_widx1)
    );
    strbuf_cam_match #(.DEPTH(DEPTH)) u_rcam0 (
        .i_valid(w_valid), .i_tags(w_tags), .i_tag(r_rtag[0]),
        .o_hit(w_rhit0), .o_idx(w_ridx0)
    );
    strbuf_cam_match #(.DEPTH(DEPTH)) u_rcam1 (
        .i_valid(w_valid), .i_tags(w_tags), .i_tag(r_rtag[1]),
        .o_hit(w_rhit1), .o_idx(w_ridx1)
    );

    // Lane 1 sees lane 0's effect: a shared tag merges, and a tag
    // evicted by lane 0's allocation counts as absent.
    assign w_alloc0 = strBufWren[0] && !w_whit0;
    assign w_idx0   = w_whit0 ? w_widx0 : r_ptr;
    assign w_same   = strBufWren[0] && (w_wtag0 == w_wtag1);
    assign w_evict  = w_alloc0 && w_whit1 && (w_widx1 == r_ptr);
    assign w_alloc1 = strBufWren[1] && !w_same && (!w_whit1 || w_evict);
    assign w_idx1   = w_same   ? w_idx0 :
                      w_alloc1 ? r_ptr + IDX_W'(w_alloc0) : w_widx1;
    assign w_nalloc  = {1'b0, w_alloc0} + {1'b0, w_alloc1};
    assign w_occ_sum = r_occ + OCC_W'(w_nalloc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_ptr <= '0;
            r_occ <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
            r_ptr <= '0;
            r_occ <= '0;
        end else begin
            if (strBufWren[0])
                r_ent[w_idx0] <= {1'b1, w_wtag0, w_data[0]};
            if (strBufWren[1])
                r_ent[w_idx1] <= {1'b1, w_wtag1, w_data[1]};
            r_ptr <= r_ptr + IDX_W'(w_nalloc);
            r_occ <= (w_occ_sum > OCC_W'(DEPTH)) ? OCC_W'(DEPTH) : w_occ_sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SB_IDLE;
            r_rtag  <= '0;
            r_wait  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
            r_hit   <= '0;
        end else begin
            unique case (r_state)
                SB_IDLE: begin
                    r_ready <= 1'b0;
                    if (strBuf_data_req) begin
                        r_rtag[0] <= strBuf_r_addr[0][ADDR_W-1:2];
                        r_rtag[1] <= strBuf_r_addr[1][ADDR_W-1:2];
                        r_wait    <= 1'b1;
                        r_state   <= SB_LOOKUP;
                    end
                end
                SB_LOOKUP: begin
                    // A flush during lookup reports misses on both lanes.
                    r_hit[0]  <= w_rhit0 && !flush;
                    r_hit[1]  <= w_rhit1 && !flush;
                    r_data[0] <= (w_rhit0 && !flush) ? r_ent[w_ridx0].data : '0;
                    r_data[1] <= (w_rhit1 && !flush) ? r_ent[w_ridx1].data : '0;
                    r_ready   <= 1'b1;
                    r_wait    <= 1'b0;
                    r_state   <= SB_IDLE;
                end
                default: r_state <= SB_IDLE;
            endcase
        end
    end

    assign wait_strBuf       = r_wait;
    assign strBuf_data_ready = r_ready;
    assign strBuf_data       = r_data;
    assign strBuf_hit        = r_hit;
    assign occupancy         = r_occ;

endmodule
